// File: rtl/frac_sad_sched.sv
// Sequencer for the fractional-pel SAD line datapath: 3-row window, per-candidate SAD accumulation, best-candidate scan.
// Optional full-pel preference build: define FRAC_FULLPEL_PREF_EN.
module frac_sad_sched #(
  parameter int NUM_CAND  = 24,
  parameter int ROW_SAD_W = 12,
  parameter int BLK_ROWS  = 8,
  parameter int SAD_W     = ROW_SAD_W + 3,
  parameter int FULL_IDX  = 12,
  parameter int FULL_BIAS = 4,
  parameter int IDX_W     = $clog2(NUM_CAND)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [63:0]                   in_ref,
  input  logic [63:0]                   in_org,
  output logic [63:0]                   dp_upper,
  output logic [63:0]                   dp_middle,
  output logic [63:0]                   dp_lower,
  output logic [63:0]                   dp_org,
  output logic                          dp_valid,
  input  logic [NUM_CAND*ROW_SAD_W-1:0] row_sad,
  input  logic                          row_sad_valid,
  output logic [IDX_W-1:0]              best_idx,
  output logic [SAD_W-1:0]              best_sad,
  output logic                          done,
  output logic [2:0]                    o_dbg_state
);

  // Input handshake: a row beat transfers on a rising edge where in_valid && in_ready.
  // in_valid may stall indefinitely; in_ready depends only on the current state.

  localparam int CNT_W = $clog2(BLK_ROWS + 1);
`ifdef FRAC_FULLPEL_PREF_EN
  localparam bit PREF_EN = 1'b1;
`else
  localparam bit PREF_EN = 1'b0;
`endif
  localparam int             INIT_IDX = PREF_EN ? FULL_IDX : 0;
  localparam logic [SAD_W:0] BIAS     = PREF_EN ? (SAD_W+1)'(FULL_BIAS) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_RUN, S_WAIT, S_SEARCH, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [63:0]        r_up, r_mid;
  logic [63:0]        r_dp_up, r_dp_mid, r_dp_low, r_dp_org;
  logic               r_dp_valid;
  logic [CNT_W-1:0]   r_beat, r_rows;
  logic [IDX_W-1:0]   r_cand, r_run_idx, r_best_idx;
  logic [SAD_W-1:0]   r_run_sad, r_best_sad;
  logic [SAD_W-1:0]   r_acc [NUM_CAND];

  logic               w_beat, w_sad_acc, w_rows_full, w_take;
  logic [SAD_W-1:0]   w_cand_sad, w_cur_sad, w_new_sad;
  logic [IDX_W-1:0]   w_cur_idx, w_new_idx;

  assign w_beat    = in_valid && in_ready;
  // Row SADs count only while the datapath can still be producing them, capped at BLK_ROWS.
  assign w_sad_acc = row_sad_valid && (r_state == S_RUN || r_state == S_WAIT) &&
                     (r_rows < CNT_W'(BLK_ROWS));
  assign w_rows_full = (r_rows == CNT_W'(BLK_ROWS)) ||
                       (w_sad_acc && r_rows == CNT_W'(BLK_ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_PRIME;
      S_PRIME:  if (w_beat && r_beat != '0) w_next = S_RUN;
      S_RUN:    if (w_beat && r_beat == CNT_W'(BLK_ROWS - 1))
                  w_next = w_rows_full ? S_SEARCH : S_WAIT;
      S_WAIT:   if (w_rows_full) w_next = S_SEARCH;
      S_SEARCH: if (r_cand == IDX_W'(NUM_CAND - 1)) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    in_ready = (r_state == S_PRIME) || (r_state == S_RUN);
    done     = (r_state == S_DONE);
  end

  // Running-best scan; candidate 0 cycle seeds the best from INIT_IDX.
  always_comb begin
    w_cand_sad = r_acc[r_cand];
    w_cur_idx  = (r_cand == '0) ? IDX_W'(INIT_IDX) : r_run_idx;
    w_cur_sad  = (r_cand == '0) ? r_acc[INIT_IDX]  : r_run_sad;
    w_take     = !(PREF_EN && r_cand == IDX_W'(FULL_IDX)) &&
                 (({1'b0, w_cand_sad} + BIAS) < {1'b0, w_cur_sad});
    w_new_idx  = w_take ? r_cand     : w_cur_idx;
    w_new_sad  = w_take ? w_cand_sad : w_cur_sad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_up       <= '0;
      r_mid      <= '0;
      r_dp_up    <= '0;
      r_dp_mid   <= '0;
      r_dp_low   <= '0;
      r_dp_org   <= '0;
      r_dp_valid <= 1'b0;
      r_beat     <= '0;
      r_rows     <= '0;
      r_cand     <= '0;
      r_run_idx  <= '0;
      r_run_sad  <= '0;
      r_best_idx <= '0;
      r_best_sad <= '0;
      for (int c = 0; c < NUM_CAND; c++) r_acc[c] <= '0;
    end else begin
      r_dp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_beat <= '0;
          r_rows <= '0;
          r_cand <= '0;
          for (int c = 0; c < NUM_CAND; c++) r_acc[c] <= '0;
        end
        S_PRIME: begin
          if (w_beat) begin
            if (r_beat == '0) begin
              r_up   <= in_ref;
              r_beat <= CNT_W'(1);
            end else begin
              r_mid  <= in_ref;
              r_beat <= '0;
            end
          end
        end
        S_RUN: begin
          if (w_beat) begin
            r_dp_up    <= r_up;
            r_dp_mid   <= r_mid;
            r_dp_low   <= in_ref;
            r_dp_org   <= in_org;
            r_dp_valid <= 1'b1;
            r_up       <= r_mid;
            r_mid      <= in_ref;
            r_beat     <= r_beat + CNT_W'(1);
          end
        end
        S_SEARCH: begin
          r_cand    <= r_cand + IDX_W'(1);
          r_run_idx <= w_new_idx;
          r_run_sad <= w_new_sad;
          if (r_cand == IDX_W'(NUM_CAND - 1)) begin
            r_best_idx <= w_new_idx;
            r_best_sad <= w_new_sad;
          end
        end
        default: ;
      endcase
      if (w_sad_acc) begin
        for (int c = 0; c < NUM_CAND; c++)
          r_acc[c] <= r_acc[c] + SAD_W'(row_sad[c*ROW_SAD_W +: ROW_SAD_W]);
        r_rows <= r_rows + CNT_W'(1);
      end
    end
  end

  assign dp_upper    = r_dp_up;
  assign dp_middle   = r_dp_mid;
  assign dp_lower    = r_dp_low;
  assign dp_org      = r_dp_org;
  assign dp_valid    = r_dp_valid;
  assign best_idx    = r_best_idx;
  assign best_sad    = r_best_sad;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_frac_sad_sched.sv
// Directed bench for frac_sad_sched: row-SAD responder model plus per-scenario check tasks.
module tb_frac_sad_sched;
  localparam int NC = 24;
  localparam int RW = 12;
  localparam int SW = 15;

  logic            clk = 1'b0;
  logic            rst, start, in_valid, row_sad_valid;
  logic [63:0]     in_ref, in_org;
  logic [NC*RW-1:0] row_sad;
  logic            busy, in_ready, dp_valid, done;
  logic [63:0]     dp_upper, dp_middle, dp_lower, dp_org;
  logic [4:0]      best_idx;
  logic [SW-1:0]   best_sad;
  logic [2:0]      dbg_state;

  frac_sad_sched dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_ref(in_ref), .in_org(in_org),
    .dp_upper(dp_upper), .dp_middle(dp_middle), .dp_lower(dp_lower), .dp_org(dp_org),
    .dp_valid(dp_valid), .row_sad(row_sad), .row_sad_valid(row_sad_valid),
    .best_idx(best_idx), .best_sad(best_sad), .done(done), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Responder / monitor state
  logic [NC*RW-1:0] rows_tbl [9];
  int          cyc = 0;
  int          rsp_idx = 0;
  int          rsp_dly = 1;
  bit          rsp_extra = 0;
  int          due_q[$];
  int          rsv8_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          dpv_bad = 0;
  bit          prev_iv = 0;
  logic [255:0] cap_q[$];

  function automatic logic [NC*RW-1:0] mk_row(input int def, input int ca, input int va,
                                              input int cb, input int vb, input int cc, input int vc);
    logic [NC*RW-1:0] r;
    for (int c = 0; c < NC; c++) begin
      r[c*RW +: RW] = RW'(def);
      if (c == ca) r[c*RW +: RW] = RW'(va);
      if (c == cb) r[c*RW +: RW] = RW'(vb);
      if (c == cc) r[c*RW +: RW] = RW'(vc);
    end
    return r;
  endfunction

  // Downstream model: answers each dp_valid with a row SAD rsp_dly cycles later.
  initial begin
    row_sad_valid = 1'b0;
    row_sad = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      row_sad_valid = 1'b0;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dp_valid) begin
        if (!prev_iv) dpv_bad++;
        cap_q.push_back({dp_upper, dp_middle, dp_lower, dp_org});
        due_q.push_back(cyc + rsp_dly);
      end
      prev_iv = in_valid;
      if (due_q.size() > 0 && due_q[0] <= cyc && rsp_idx < 9) begin
        void'(due_q.pop_front());
        row_sad = rows_tbl[rsp_idx];
        row_sad_valid = 1'b1;
        if (rsp_idx == 7) begin
          rsv8_cyc = cyc;
          if (rsp_extra) due_q.push_front(cyc + 1);
        end
        rsp_idx++;
      end
    end
  end

  task automatic run_search(input bit gap, input int dly, input int start_at, input bit extra,
                            input int nbeats, output bit got_done);
    bit acc;
    rsp_idx = 0;
    due_q.delete();
    cap_q.delete();
    rsp_dly = dly;
    rsp_extra = extra;
    done_cnt = 0;
    dpv_bad = 0;
    got_done = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      logic [7:0] rb, ob;
      rb = 8'(b);
      ob = 8'h80 + 8'(b);
      in_ref = {8{rb}};
      in_org = {8{ob}};
      in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        acc = in_ready;
        if (b == start_at && t == 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      in_valid = 1'b0;
      if (gap) @(negedge clk);
    end
    if (nbeats == 10) begin
      for (int t = 0; t < 100 && !got_done; t++) begin
        if (done) got_done = 1'b1;
        else @(negedge clk);
      end
    end
  endtask

  task automatic fill_basic();
    for (int r = 0; r < 9; r++) rows_tbl[r] = mk_row(50, 5, 10, -1, 0, -1, 0);
    rows_tbl[8] = mk_row(4095, 9, 0, -1, 0, -1, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_ref = '0; in_org = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, in_ready, dp_valid, done} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 0000", {busy, in_ready, dp_valid, done});
    end
    n_vec++;
    if ({best_idx, best_sad} !== '0) begin
      n_err++;
      $display("FAIL reset_best got idx %0d sad %0d want 0 0", best_idx, best_sad);
    end
    n_vec++;
    if ({dp_upper, dp_middle, dp_lower, dp_org} !== '0) begin
      n_err++;
      $display("FAIL reset_dp got %h want 0", {dp_upper, dp_middle, dp_lower, dp_org});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit gd;
    fill_basic();
    run_search(0, 1, -1, 0, 10, gd);
    n_vec++;
    if (gd !== 1'b1) begin n_err++; $display("FAIL basic_done got %b want 1", gd); end
    n_vec++;
    if (best_idx !== 5'd5) begin n_err++; $display("FAIL basic_idx got %0d want 5", best_idx); end
    n_vec++;
    if (best_sad !== 15'd80) begin n_err++; $display("FAIL basic_sad got %0d want 80", best_sad); end
    @(negedge clk);
    n_vec++;
    if (done_cyc - rsv8_cyc !== 25) begin
      n_err++;
      $display("FAIL basic_latency got %0d want 25", done_cyc - rsv8_cyc);
    end
    n_vec++;
    if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL basic_pulse got %b want 00", {done, busy}); end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({best_idx, best_sad} !== {5'd5, 15'd80}) begin
      n_err++;
      $display("FAIL basic_hold got idx %0d sad %0d want 5 80", best_idx, best_sad);
    end
  endtask

  task automatic test_window();
    bit gd;
    logic [7:0] kb, ob;
    fill_basic();
    run_search(0, 1, -1, 0, 10, gd);
    n_vec++;
    if (cap_q.size() !== 8) begin n_err++; $display("FAIL win_count got %0d want 8", cap_q.size()); end
    for (int k = 0; k < 8 && k < cap_q.size(); k++) begin
      kb = 8'(k);
      ob = 8'h82 + 8'(k);
      n_vec++;
      if (cap_q[k] !== {{8{kb}}, {8{kb + 8'd1}}, {8{kb + 8'd2}}, {8{ob}}}) begin
        n_err++;
        $display("FAIL win_row%0d got %h want %h", k, cap_q[k],
                 {{8{kb}}, {8{kb + 8'd1}}, {8{kb + 8'd2}}, {8{ob}}});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_tie();
    bit gd;
    for (int r = 0; r < 9; r++) rows_tbl[r] = mk_row(100, 3, 5, 7, 5, 12, (r == 7) ? 7 : 5);
    run_search(0, 1, -1, 0, 10, gd);
    n_vec++;
`ifdef FRAC_FULLPEL_PREF_EN
    if ({gd, best_idx, best_sad} !== {1'b1, 5'd12, 15'd42}) begin
      n_err++;
      $display("FAIL tie got done %b idx %0d sad %0d want 1 12 42", gd, best_idx, best_sad);
    end
`else
    if ({gd, best_idx, best_sad} !== {1'b1, 5'd3, 15'd40}) begin
      n_err++;
      $display("FAIL tie got done %b idx %0d sad %0d want 1 3 40", gd, best_idx, best_sad);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit gd;
    fill_basic();
    run_search(1, 3, -1, 0, 10, gd);
    n_vec++;
    if ({gd, best_idx, best_sad} !== {1'b1, 5'd5, 15'd80}) begin
      n_err++;
      $display("FAIL bp_result got done %b idx %0d sad %0d want 1 5 80", gd, best_idx, best_sad);
    end
    @(negedge clk);
    n_vec++;
    if (dpv_bad !== 0) begin n_err++; $display("FAIL bp_dpvalid got %0d stray pulses want 0", dpv_bad); end
    n_vec++;
    if (done_cyc - rsv8_cyc !== 25) begin
      n_err++;
      $display("FAIL bp_latency got %0d want 25", done_cyc - rsv8_cyc);
    end
  endtask

  task automatic test_start_busy();
    bit gd;
    fill_basic();
    run_search(0, 1, 4, 1, 10, gd);
    n_vec++;
    if ({gd, best_idx, best_sad} !== {1'b1, 5'd5, 15'd80}) begin
      n_err++;
      $display("FAIL busy_result got done %b idx %0d sad %0d want 1 5 80", gd, best_idx, best_sad);
    end
    repeat (30) @(negedge clk);
    n_vec++;
    if ({done_cnt, busy} !== {32'd1, 1'b0}) begin
      n_err++;
      $display("FAIL busy_once got dones %0d busy %b want 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit gd;
    fill_basic();
    run_search(0, 1, -1, 0, 5, gd);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, in_ready, dp_valid, done, best_sad} !== '0) begin
      n_err++;
      $display("FAIL rstmid_ctrl got busy %b rdy %b dpv %b done %b sad %0d want all 0",
               busy, in_ready, dp_valid, done, best_sad);
    end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    n_vec++;
    if (done_cnt !== 0) begin n_err++; $display("FAIL rstmid_nodone got %0d want 0", done_cnt); end
    for (int r = 0; r < 9; r++) rows_tbl[r] = mk_row(9, 20, 3, -1, 0, -1, 0);
    run_search(0, 1, -1, 0, 10, gd);
    n_vec++;
    if ({gd, best_idx, best_sad} !== {1'b1, 5'd20, 15'd24}) begin
      n_err++;
      $display("FAIL rstmid_fresh got done %b idx %0d sad %0d want 1 20 24", gd, best_idx, best_sad);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_window();
    test_tie();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
